// File: rtl/expr_emitter_pkg.sv
// Shared constants for the expression emitter: ASCII characters, FSM state
// encodings and the operator bit encoding.
package expr_emitter_pkg;

   localparam logic [7:0] CH_ZERO = 8'h30;
   localparam logic [7:0] CH_PLUS = 8'h2B;
   localparam logic [7:0] CH_STAR = 8'h2A;
   localparam logic [7:0] CH_BAD  = 8'h3F;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DIGIT = 2'd1;
   localparam logic [1:0] ST_OP    = 2'd2;

   localparam logic OP_PLUS = 1'b0;
   localparam logic OP_STAR = 1'b1;

   function automatic logic [7:0] op_char(input logic op);
      return (op == OP_STAR) ? CH_STAR : CH_PLUS;
   endfunction

endpackage

// File: rtl/expr_emitter_bcd_to_ascii.sv
// Combinational BCD digit to ASCII character; non-decimal codes map to '?'
// and raise bad.
module bcd_to_ascii
   import expr_emitter_pkg::*;
(
   input  logic [3:0] d,
   output logic [7:0] ch,
   output logic       bad
);

   always_comb begin
      bad = (d > 4'd9);
      ch  = bad ? CH_BAD : (CH_ZERO + {4'h0, d});
   end

endmodule

// File: rtl/expr_emitter.sv
// Serializes digit (op digit)* into an ASCII byte stream, one character per
// enabled clock, framed by a start/busy/done handshake.
module expr_emitter
   import expr_emitter_pkg::*;
#(
   parameter int MAX_OPND = 8,
   parameter int LEN_W    = 4
)(
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  start,
   input  logic                  en,
   input  logic [LEN_W-1:0]      len,
   input  logic [4*MAX_OPND-1:0] digits,
   input  logic [MAX_OPND-2:0]   ops,
   output logic [7:0]            out,
   output logic                  valid,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int IDX_W = (MAX_OPND > 1) ? $clog2(MAX_OPND) : 1;

   logic [1:0]            st;
   logic [IDX_W-1:0]      idx;
   logic [LEN_W-1:0]      len_q;
   logic [4*MAX_OPND-1:0] dig_q;
   logic [MAX_OPND-2:0]   ops_q;

   logic [3:0] cur_d;
   logic [7:0] cur_ch;
   logic       cur_bad;
   logic       len_ok;
   logic       last;

   // Operand 0 is emitted on the accepting edge, before the latch holds it,
   // so IDLE reads the live input instead of the latched copy.
   always_comb begin
      cur_d = digits[3:0];
      if (st != ST_IDLE) begin
         for (int i = 0; i < MAX_OPND; i++) begin
            if (idx == IDX_W'(i)) cur_d = dig_q[4*i +: 4];
         end
      end
      len_ok = (len != '0) && (len <= LEN_W'(MAX_OPND));
      last   = (LEN_W'(idx) == (len_q - LEN_W'(1)));
   end

   bcd_to_ascii u_b2a (
      .d   (cur_d),
      .ch  (cur_ch),
      .bad (cur_bad)
   );

   always_ff @(posedge clk) begin
      if (st == ST_IDLE && start && len_ok) begin
         len_q <= len;
         dig_q <= digits;
         ops_q <= ops;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         st    <= ST_IDLE;
         idx   <= '0;
         out   <= 8'h00;
         valid <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         valid <= 1'b0;
         done  <= 1'b0;
         case (st)
            ST_IDLE: begin
               if (start) begin
                  if (len_ok) begin
                     out   <= cur_ch;
                     valid <= 1'b1;
                     err   <= cur_bad;
                     if (len == LEN_W'(1)) begin
                        done <= 1'b1;
                     end else begin
                        busy <= 1'b1;
                        idx  <= IDX_W'(1);
                        st   <= ST_OP;
                     end
                  end else begin
                     err  <= 1'b1;
                     done <= 1'b1;
                  end
               end
            end
            ST_OP: begin
               if (en) begin
                  out   <= op_char(ops_q[idx - IDX_W'(1)]);
                  valid <= 1'b1;
                  st    <= ST_DIGIT;
               end
            end
            ST_DIGIT: begin
               if (en) begin
                  out   <= cur_ch;
                  valid <= 1'b1;
                  if (cur_bad) err <= 1'b1;
                  if (last) begin
                     busy <= 1'b0;
                     done <= 1'b1;
                     st   <= ST_IDLE;
                  end else begin
                     idx <= idx + IDX_W'(1);
                     st  <= ST_OP;
                  end
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_expr_emitter.sv
// Scoreboard bench for expr_emitter: expected characters are queued when an
// expression is launched and popped as valid characters appear.
module tb_expr_emitter;

   logic        clk = 1'b0;
   logic        clr;
   logic        start;
   logic        en;
   logic [3:0]  len;
   logic [31:0] digits;
   logic [6:0]  ops;
   logic [7:0]  out;
   logic        valid, busy, done, err;

   typedef struct {
      logic [7:0] ch;
      logic       last;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;
   int   vcnt  = 0;
   bit   busy_seen = 0;
   bit   rej_pend  = 0;

   expr_emitter #(.MAX_OPND(8), .LEN_W(4)) dut (
      .clk    (clk),
      .clr    (clr),
      .start  (start),
      .en     (en),
      .len    (len),
      .digits (digits),
      .ops    (ops),
      .out    (out),
      .valid  (valid),
      .busy   (busy),
      .done   (done),
      .err    (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] mdl_char(input logic [3:0] d);
      return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
   endfunction

   task automatic push_expr(input int n, input logic [31:0] dg, input logic [6:0] op,
                            output bit any_bad);
      exp_t e;
      any_bad = 0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            e.ch = op[i-1] ? 8'h2A : 8'h2B;
            e.last = 1'b0;
            sbq.push_back(e);
         end
         e.ch = mdl_char(dg[4*i +: 4]);
         e.last = (i == n - 1);
         if (dg[4*i +: 4] > 4'd9) any_bad = 1;
         sbq.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (!clr) begin
         exp_t e;
         if (busy) busy_seen = 1;
         if (valid) begin
            vcnt++;
            if (sbq.size() == 0) begin
               chk("sb_empty", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("char", out, e.ch);
               chk("done_flag", done, e.last);
            end
         end else if (done) begin
            chk("reject_expected", rej_pend, 1);
            rej_pend = 0;
         end
      end
   end

   task automatic run(input int n, input logic [31:0] dg, input logic [6:0] op, input bit rnd);
      bit xb;
      int cyc;
      push_expr(n, dg, op, xb);
      vcnt = 0;
      busy_seen = 0;
      len = 4'(n);
      digits = dg;
      ops = op;
      en = 1'b1;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 200) begin
         en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk); #1;
         cyc++;
      end
      if (!done) chk("timeout", 0, 1);
      en = 1'b1;
      if (!rnd) begin
         chk("vcnt", vcnt, 2*n - 1);
         chk("latency", cyc, 2*n - 2);
      end
      chk("busy_seen", busy_seen, (n > 1));
      @(negedge clk); #1;
      chk("busy_end", busy, 0);
      chk("err_end", err, xb);
      chk("sb_left", sbq.size(), 0);
   endtask

   task automatic reject(input logic [3:0] l);
      rej_pend = 1;
      len = l;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      chk("rej_done", done, 1);
      chk("rej_err", err, 1);
      chk("rej_valid", valid, 0);
      @(negedge clk); #1;
      chk("rej_err_hold", err, 1);
      chk("rej_busy", busy, 0);
   endtask

   initial begin
      bit xb;
      logic [31:0] dg;
      clr = 1'b1;
      start = 1'b0;
      en = 1'b1;
      len = '0;
      digits = '0;
      ops = '0;
      #3;
      chk("rst_out", out, 0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      @(negedge clk); #1;
      clr = 1'b0;
      @(negedge clk); #1;

      // "3+0*7"
      run(3, 32'h0000_0703, 7'b000_0010, 0);
      // single operand
      run(1, 32'h0000_0009, 7'b0, 0);

      // stall in OP/DIGIT, with an ignored start during the stall
      push_expr(2, 32'h0000_0021, 7'b0, xb);
      vcnt = 0;
      len = 4'd2; digits = 32'h0000_0021; ops = 7'b0; en = 1'b1; start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
      en = 1'b0;
      @(negedge clk); #1;
      chk("stall_valid0", valid, 0);
      chk("stall_out0", out, 8'h2B);
      start = 1'b1; len = 4'd3; digits = 32'h0000_0999; ops = 7'h7F;
      @(negedge clk); #1;
      chk("stall_valid1", valid, 0);
      chk("stall_out1", out, 8'h2B);
      chk("stall_busy", busy, 1);
      start = 1'b0; en = 1'b1;
      @(negedge clk); #1;
      chk("stall_done", done, 1);
      chk("stall_vcnt", vcnt, 3);
      @(negedge clk); #1;
      chk("stall_busy_end", busy, 0);
      chk("stall_sb_left", sbq.size(), 0);

      // illegal lengths, then a legal start clears err
      reject(4'd0);
      reject(4'd9);
      run(2, 32'h0000_0045, 7'b1, 0);

      // invalid BCD in operand 1
      run(2, 32'h0000_00C5, 7'b0, 0);
      chk("bad_digit_err", err, 1);

      // full-length expression
      run(8, 32'h8765_4321, 7'b101_0110, 0);

      // random expressions with random stalls
      for (int k = 0; k < 6; k++) begin
         dg = '0;
         for (int j = 0; j < 8; j++) dg[4*j +: 4] = 4'($urandom_range(0, 11));
         run($urandom_range(1, 8), dg, 7'($urandom_range(0, 127)), 1);
      end

      // asynchronous clear mid-stream
      push_expr(8, 32'h1111_1111, 7'b0, xb);
      len = 4'd8; digits = 32'h1111_1111; ops = 7'b0; en = 1'b1; start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk("pre_clr_busy", busy, 1);
      chk("pre_clr_valid", valid, 1);
      #2 clr = 1'b1;
      #1;
      chk("clr_out", out, 0);
      chk("clr_valid", valid, 0);
      chk("clr_busy", busy, 0);
      chk("clr_done", done, 0);
      chk("clr_err", err, 0);
      sbq.delete();
      @(negedge clk); #1;
      clr = 1'b0;
      @(negedge clk); #1;
      chk("post_clr_done", done, 0);
      chk("post_clr_valid", valid, 0);
      run(3, 32'h0000_0246, 7'b01, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
